// File: rtl/oam_dma.sv
// Sprite DMA: on a $4014 trigger, halts the CPU and copies one 256-byte page
// to the PPU OAM data port ($2004), aligning so every read is on an even CPU cycle.
module oam_dma (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cpu_ce,
   input  logic        start,
   input  logic [7:0]  page,
   input  logic [7:0]  bus_data_in,
   output logic        cpu_halt,
   output logic        busy,
   output logic [15:0] bus_addr,
   output logic [7:0]  bus_data_out,
   output logic        bus_we,
   output logic        bus_drive
);

   typedef enum logic [2:0] {IDLE, HALT, ALIGN, READ, WRITE} state_e;

   state_e     state_q, state_d;
   logic       parity_q, parity_d;
   logic       start_q, start_d;
   logic [7:0] page_q, page_d;
   logic [7:0] idx_q, idx_d;
   logic [7:0] latch_q, latch_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         parity_q <= 1'b0;
         start_q  <= 1'b0;
         page_q   <= 8'h00;
         idx_q    <= 8'h00;
         latch_q  <= 8'h00;
      end else begin
         state_q  <= state_d;
         parity_q <= parity_d;
         start_q  <= start_d;
         page_q   <= page_d;
         idx_q    <= idx_d;
         latch_q  <= latch_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      parity_d = parity_q;
      start_d  = start_q;
      page_d   = page_q;
      idx_d    = idx_q;
      latch_d  = latch_q;
      if (cpu_ce) begin
         parity_d = ~parity_q;
         start_d  = start;
         case (state_q)
            IDLE: begin
               if (start && !start_q) begin
                  state_d = HALT;
                  page_d  = page;
                  idx_d   = 8'h00;
               end
            end
            // The cycle after HALT has the opposite parity; reads must land on even cycles.
            HALT:  state_d = parity_q ? READ : ALIGN;
            ALIGN: state_d = READ;
            READ: begin
               latch_d = bus_data_in;
               state_d = WRITE;
            end
            WRITE: begin
               if (idx_q == 8'hFF) begin
                  state_d = IDLE;
               end else begin
                  idx_d   = idx_q + 8'h01;
                  state_d = READ;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      cpu_halt     = 1'b0;
      busy         = 1'b0;
      bus_addr     = 16'h0000;
      bus_data_out = 8'h00;
      bus_we       = 1'b0;
      bus_drive    = 1'b0;
      case (state_q)
         HALT, ALIGN: begin
            cpu_halt = 1'b1;
            busy     = 1'b1;
         end
         READ: begin
            cpu_halt  = 1'b1;
            busy      = 1'b1;
            bus_drive = 1'b1;
            bus_addr  = {page_q, idx_q};
         end
         WRITE: begin
            cpu_halt     = 1'b1;
            busy         = 1'b1;
            bus_drive    = 1'b1;
            bus_we       = 1'b1;
            bus_addr     = 16'h2004;
            bus_data_out = latch_q;
         end
         default: ;
      endcase
   end

endmodule
